// File: rtl/seg7_reader.sv
// Seven-segment receive-side reader: synchronises and deglitches a segment bus,
// decodes committed glyphs back to hex digits and checks they advance by one modulo MODULUS.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned MODULUS       = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       blank,
    output logic       dp,
    output logic       update,
    output logic       seq_err,
    output logic [7:0] update_count,
    output logic [7:0] err_count
);

    localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [4:0] MOD_W       = 5'(MODULUS);

    // Returns {valid, digit}; digit is don't-care when valid is 0.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   return 5'h10;
            7'h06:   return 5'h11;
            7'h5B:   return 5'h12;
            7'h4F:   return 5'h13;
            7'h66:   return 5'h14;
            7'h6D:   return 5'h15;
            7'h7D:   return 5'h16;
            7'h07:   return 5'h17;
            7'h7F:   return 5'h18;
            7'h6F:   return 5'h19;
            7'h77:   return 5'h1A;
            7'h7C:   return 5'h1B;
            7'h39:   return 5'h1C;
            7'h5E:   return 5'h1D;
            7'h79:   return 5'h1E;
            7'h71:   return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic [3:0] next_digit(input logic [3:0] d);
        logic [4:0] s;
        s = {1'b0, d} + 5'd1;
        return 4'(s % MOD_W);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic inc);
        return (inc && (c != 8'hFF)) ? c + 8'd1 : c;
    endfunction

    logic [7:0] s1_q, s1_d, s2_q, s2_d;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] pat_q, pat_d;
    logic       have_prev_q, have_prev_d;
    logic [3:0] digit_q, digit_d;
    logic       valid_q, valid_d;
    logic       blank_q, blank_d;
    logic       dp_q, dp_d;
    logic       update_q, update_d;
    logic       seq_err_q, seq_err_d;
    logic [7:0] upd_cnt_q, upd_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       commit;
    logic [4:0] dec;

    always_comb begin
        s1_d        = seg_in;
        s2_d        = s1_q;
        cnt_d       = cnt_q;
        pat_d       = pat_q;
        have_prev_d = have_prev_q;
        digit_d     = digit_q;
        valid_d     = valid_q;
        blank_d     = blank_q;
        dp_d        = dp_q;
        update_d    = 1'b0;
        seq_err_d   = 1'b0;
        dec         = decode(s2_q[6:0]);

        if (s1_q != s2_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q < STABLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end

        // Commit exactly once per stable run, on the SC-1 -> SC step.
        commit = (s1_q == s2_q) && (cnt_q == STABLE_LAST);

        if (commit) begin
            dp_d = s2_q[7];
            if (s2_q[6:0] != pat_q) begin
                update_d = 1'b1;
                pat_d    = s2_q[6:0];
                blank_d  = (s2_q[6:0] == 7'h00);
                valid_d  = dec[4];
                if (dec[4]) begin
                    digit_d     = dec[3:0];
                    seq_err_d   = have_prev_q && (dec[3:0] != next_digit(digit_q));
                    have_prev_d = 1'b1;
                end else begin
                    seq_err_d   = (s2_q[6:0] != 7'h00);
                    have_prev_d = 1'b0;
                end
            end
        end

        upd_cnt_d = sat_inc(upd_cnt_q, update_d);
        err_cnt_d = sat_inc(err_cnt_q, seq_err_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= 8'h00;
            s2_q        <= 8'h00;
            cnt_q       <= 8'd0;
            pat_q       <= 7'h00;
            have_prev_q <= 1'b0;
            digit_q     <= 4'd0;
            valid_q     <= 1'b0;
            blank_q     <= 1'b1;
            dp_q        <= 1'b0;
            update_q    <= 1'b0;
            seq_err_q   <= 1'b0;
            upd_cnt_q   <= 8'd0;
            err_cnt_q   <= 8'd0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            have_prev_q <= have_prev_d;
            digit_q     <= digit_d;
            valid_q     <= valid_d;
            blank_q     <= blank_d;
            dp_q        <= dp_d;
            update_q    <= update_d;
            seq_err_q   <= seq_err_d;
            upd_cnt_q   <= upd_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign digit        = digit_q;
    assign digit_valid  = valid_q;
    assign blank        = blank_q;
    assign dp           = dp_q;
    assign update       = update_q;
    assign seq_err      = seq_err_q;
    assign update_count = upd_cnt_q;
    assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with default parameters (STABLE_CYCLES=16, MODULUS=10).
module tb_seg7_reader;

    logic       clk;
    logic       rst;
    logic [7:0] seg_in;
    logic [3:0] digit;
    logic       digit_valid;
    logic       blank;
    logic       dp;
    logic       update;
    logic       seq_err;
    logic [7:0] update_count;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;

    seg7_reader #(.STABLE_CYCLES(16), .MODULUS(10)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in),
        .digit(digit), .digit_valid(digit_valid), .blank(blank), .dp(dp),
        .update(update), .seq_err(seq_err),
        .update_count(update_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive p from a falling edge and hold for n cycles; the commit pulse is
    // expected exactly 18 edges later and nowhere else in the window.
    task automatic apply(input string tag, input logic [7:0] p, input int n,
                         input logic exp_upd, input logic exp_err);
        logic got_upd, got_err, stray;
        got_upd = 1'b0; got_err = 1'b0; stray = 1'b0;
        seg_in = p;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == 18) begin
                got_upd = update;
                got_err = seq_err;
            end else if (update || seq_err) begin
                stray = 1'b1;
            end
        end
        if (n >= 18) begin
            check({tag, "_upd"}, 32'(got_upd), 32'(exp_upd));
            check({tag, "_err"}, 32'(got_err), 32'(exp_err));
        end
        check({tag, "_stray"}, 32'(stray), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digit"}, 32'(digit), 32'd0);
        check({tag, "_valid"}, 32'(digit_valid), 32'd0);
        check({tag, "_blank"}, 32'(blank), 32'd1);
        check({tag, "_dp"}, 32'(dp), 32'd0);
        check({tag, "_update"}, 32'(update), 32'd0);
        check({tag, "_seqerr"}, 32'(seq_err), 32'd0);
        check({tag, "_ucnt"}, 32'(update_count), 32'd0);
        check({tag, "_ecnt"}, 32'(err_count), 32'd0);
    endtask

    logic [7:0] glyphs [0:10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D,
                                  8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h3F};

    initial begin
        rst = 1'b1;
        seg_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;

        apply("idle", 8'h00, 100, 1'b0, 1'b0);
        check("idle_blank", 32'(blank), 32'd1);
        check("idle_ucnt", 32'(update_count), 32'd0);
        check("idle_ecnt", 32'(err_count), 32'd0);

        for (int k = 0; k < 11; k++) begin
            apply($sformatf("seq%0d", k), glyphs[k], 30, 1'b1, 1'b0);
            check($sformatf("seq%0d_digit", k), 32'(digit), 32'(k % 10));
            check($sformatf("seq%0d_valid", k), 32'(digit_valid), 32'd1);
        end
        check("seq_ucnt", 32'(update_count), 32'd11);
        check("seq_ecnt", 32'(err_count), 32'd0);

        apply("skip1", 8'h06, 30, 1'b1, 1'b0);
        apply("skip3", 8'h4F, 30, 1'b1, 1'b1);
        check("skip_ecnt", 32'(err_count), 32'd1);
        apply("blank", 8'h00, 30, 1'b1, 1'b0);
        check("blank_blank", 32'(blank), 32'd1);
        check("blank_valid", 32'(digit_valid), 32'd0);
        apply("restart", 8'h3F, 30, 1'b1, 1'b0);
        check("restart_digit", 32'(digit), 32'd0);
        check("restart_ecnt", 32'(err_count), 32'd1);
        check("restart_ucnt", 32'(update_count), 32'd15);

        apply("hold1", 8'h06, 30, 1'b1, 1'b0);
        apply("glitch", 8'h7F, 5, 1'b0, 1'b0);
        apply("return", 8'h06, 30, 1'b0, 1'b0);
        check("glitch_digit", 32'(digit), 32'd1);
        check("glitch_ucnt", 32'(update_count), 32'd16);
        apply("dpon", 8'h86, 30, 1'b0, 1'b0);
        check("dpon_dp", 32'(dp), 32'd1);
        check("dpon_ucnt", 32'(update_count), 32'd16);

        apply("inval", 8'h55, 30, 1'b1, 1'b1);
        check("inval_valid", 32'(digit_valid), 32'd0);
        check("inval_digit", 32'(digit), 32'd1);
        check("inval_blank", 32'(blank), 32'd0);
        check("inval_dp", 32'(dp), 32'd0);
        check("inval_ecnt", 32'(err_count), 32'd2);

        seg_in = 8'h5B;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        apply("postrst", 8'h5B, 30, 1'b1, 1'b0);
        check("postrst_digit", 32'(digit), 32'd2);

        for (int k = 0; k < 253; k++) begin
            seg_in = (k % 2 == 0) ? 8'h55 : 8'h49;
            repeat (20) @(negedge clk);
        end
        check("sat_ecnt253", 32'(err_count), 32'd253);
        check("sat_ucnt254", 32'(update_count), 32'd254);
        for (int k = 253; k < 258; k++) begin
            seg_in = (k % 2 == 0) ? 8'h55 : 8'h49;
            repeat (20) @(negedge clk);
        end
        check("sat_ecnt", 32'(err_count), 32'd255);
        check("sat_ucnt", 32'(update_count), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Receive-side companion to the team's seven-segment counter designs. Samples a segment-pattern bus (e.g. looped back from a display driver's `uo_out`), synchronises and deglitches it, decodes the stable pattern back to a hex digit, and checks that successive digits advance by one modulo `MODULUS`. It sits on the receive side of the segment interface, as an on-chip self-check or as a standalone reader fed from `ui_in`.

## Interface
- `STABLE_CYCLES`, default 16: consecutive identical synchronised samples required before a pattern is committed; legal range 1..255.
- `MODULUS`, default 10: the digit sequence wraps from `MODULUS-1` to 0; legal range 2..16.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `seg_in` input 8: segment bus; bit 7 = dp; bits 6:0 = {g,f,e,d,c,b,a}; 1 = segment lit.
- `digit` output 4: last committed decoded value, 0..15.
- `digit_valid` output 1: committed pattern is a legal hex glyph.
- `blank` output 1: committed segment pattern is 0x00.
- `dp` output 1: committed bit 7.
- `update` output 1: one-cycle pulse on commit of a changed 7-bit pattern.
- `seq_err` output 1: one-cycle pulse, coincident with `update`, on a sequence violation.
- `update_count` output 8: number of `update` pulses, saturating at 255.
- `err_count` output 8: number of `seq_err` pulses, saturating at 255.

## Operation
- Synchroniser: `s1 <= seg_in`, `s2 <= s1`.
- Stability counter `cnt` (8 bit):
  - `cnt <= 0` when `s1 != s2`.
  - `cnt <= cnt+1` when `s1 == s2` and `cnt < STABLE_CYCLES`.
  - Holds at `STABLE_CYCLES`.
- Commit: on the edge where `cnt` goes `STABLE_CYCLES-1 -> STABLE_CYCLES`, `s2` is committed. Exactly one commit per stable run.
- On commit:
  - `dp` always takes `s2[7]`.
  - If `s2[6:0]` equals the committed 7-bit pattern, nothing else changes and no pulse is generated. Dp-only changes and glitch-and-return produce no `update`.
- Decode table (pattern -> digit):
  - Digits 0-9: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - Letters: 0x77→A, 0x7C→b, 0x39→C, 0x5E→d, 0x79→E, 0x71→F.
  - Any other pattern gives `digit_valid=0` and leaves `digit` holding its previous value.
  - 0x00 gives `blank=1`, `digit_valid=0`.
- Sequence check, evaluated on each changed commit. A `have_prev` flag records whether a previous valid digit exists.
  - New pattern valid and `have_prev=1`: `seq_err` fires if new ≠ (prev+1) mod `MODULUS`. Digits ≥ `MODULUS` always err.
  - New pattern valid and `have_prev=0`: no check; set `have_prev`.
  - New pattern invalid and not blank: `seq_err` fires; clear `have_prev`.
  - Blank: no error; clear `have_prev`.
- Counters increment on their pulse, saturating at 255 (no wrap).

## Timing
- Reset values:
  - `s1`, `s2`, committed pattern = 0x00; `cnt` = 0; `have_prev` = 0.
  - `digit` = 0; `digit_valid` = 0; `blank` = 1; `dp` = 0.
  - `update`, `seq_err` = 0; both counters = 0.
- Latency: a new value held on `seg_in` from sampling edge 1 is committed at edge `STABLE_CYCLES+2`. `update`/`seq_err` and the new `digit`/`digit_valid`/`blank`/`dp` are visible in the cycle after that edge.
  - Default `STABLE_CYCLES=16`: 18 edges.
- Any change of `s2` before commit restarts the count. A pattern toggling with period ≤ `STABLE_CYCLES` is never committed.
- All outputs are registered; no combinational path from `seg_in`.
- `rst` mid-run: on the next edge all state returns to reset values and any pending commit is discarded. The first commit after reset performs no sequence check.
- Back-to-back commits are at least `STABLE_CYCLES+1` cycles apart.

## Test plan
- Reset, hold `seg_in`=0x00 for 100 cycles -> no `update`; `blank`=1; both counters 0.
- Apply 0x3F, 0x06, 0x5B … 0x6F, then 0x3F, each held 30 cycles (`MODULUS`=10) -> 11 `update` pulses, each 18 edges after the change; `digit` 0..9,0; `seq_err` never fires; `update_count`=11.
- Sequence 0x06 then 0x4F (1→3) -> second `update` coincides with `seq_err`; `err_count`=1. Then 0x00, then 0x3F -> no further errors.
- Hold 0x06, insert a 5-cycle glitch of 0x7F, return to 0x06 -> no `update`. Toggle bit 7 alone and hold -> `dp` follows after 18 edges with no `update`.
- Hold invalid 0x55 -> `update`=1, `seq_err`=1, `digit_valid`=0, `digit` unchanged.
- Assert `rst` 5 cycles after a pattern change -> no commit; all outputs at reset values. Drive more than 255 erroring updates -> `err_count` saturates at 255.
